// File: rtl/grey_counter_n_if.sv
// Bundles the control inputs and count/status outputs of grey_counter_n.
// master: the driver (logic-analyzer side); slave: the counter itself.
interface grey_counter_n_if #(
    parameter int WIDTH = 6
);
    logic             incr;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat;
    logic [WIDTH-1:0] grey;
    logic [WIDTH-1:0] bin;
    logic             wrap;
    logic             at_max;
    logic             at_min;
    logic             err;

    modport master (
        output incr, dir, load, load_val, sat,
        input  grey, bin, wrap, at_max, at_min, err
    );

    modport slave (
        input  incr, dir, load, load_val, sat,
        output grey, bin, wrap, at_max, at_min, err
    );
endinterface

// File: rtl/grey_counter_n.sv
// grey_counter_n: parametrised up/down Gray-code counter with synchronous
// load, wrap/saturate ends, binary readback, wrap pulse and end flags.
// Both the Gray and binary counts are held in their own registers, so the
// Gray output is glitch-free.
// Optional macro GREY_COUNTER_N_CHECK_EN builds a sticky Gray-adjacency
// checker driving err; without it err is tied low.
module grey_counter_n #(
    parameter int          WIDTH     = 6,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    grey_counter_n_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GREY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] grey_q;
    logic             wrap_q;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_grey;
    logic             next_wrap;

    // Next count: load beats step, step beats hold; the ends either wrap or saturate.
    always_comb begin
        next_bin  = bin_q;
        next_wrap = 1'b0;
        if (bus.load) begin
            next_bin = bus.load_val;
        end else if (bus.incr) begin
            if (bus.dir) begin
                if (bin_q != MAX_VAL) begin
                    next_bin = bin_q + WIDTH'(1);
                end else if (!bus.sat) begin
                    next_bin  = '0;
                    next_wrap = 1'b1;
                end
            end else begin
                if (bin_q != '0) begin
                    next_bin = bin_q - WIDTH'(1);
                end else if (!bus.sat) begin
                    next_bin  = MAX_VAL;
                    next_wrap = 1'b1;
                end
            end
        end
        next_grey = next_bin ^ (next_bin >> 1);
    end

    // Count registers: the Gray code is registered directly from the next binary value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            grey_q <= RST_GREY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            grey_q <= next_grey;
            wrap_q <= next_wrap;
        end
    end

    assign bus.bin    = bin_q;
    assign bus.grey   = grey_q;
    assign bus.wrap   = wrap_q;
    assign bus.at_max = (bin_q == MAX_VAL);
    assign bus.at_min = (bin_q == '0);

`ifdef GREY_COUNTER_N_CHECK_EN
    logic [WIDTH-1:0] grey_d;
    logic             prev_load;
    logic             err_q;
    logic [WIDTH-1:0] grey_diff;
    logic             multi_bit;

    // A change of more than one bit is a fault; zero- or one-bit changes are fine.
    always_comb begin
        grey_diff = grey_q ^ grey_d;
        multi_bit = (grey_diff & (grey_diff - WIDTH'(1))) != '0;
    end

    // Remember the previous Gray value and whether it came from a load; latch any fault until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grey_d    <= RST_GREY;
            prev_load <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            grey_d    <= grey_q;
            prev_load <= bus.load;
            if (!prev_load && multi_bit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/grey_counter_n.md
Name: grey_counter_n

Overview:
Parametrised up/down Gray-code counter. It is the next generation of the fixed 6-bit grey_code6 counter in the user project.
- Adds: configurable width and reset value, direction control, synchronous load, wrap/saturate mode, binary readback, wrap pulse, end-of-range flags.
- Sits beside the ring oscillators under user_project_wrapper. Driven from logic-analyzer bits; outputs returned on la_data_out.

Parameters:
- WIDTH, 6: counter width in bits; legal range 2..32.
- RESET_VAL, 0: binary count loaded on reset; must be < 2^WIDTH.

Ports:
- clk  input  1  counter clock (user_clock2 at top level)
- rst  input  1  asynchronous, active-high reset
- incr  input  1  step enable; one step per clk edge while high
- dir  input  1  1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  binary value to load
- sat  input  1  1 = saturate at ends, 0 = wrap around
- grey  output  WIDTH  registered Gray-code count
- bin  output  WIDTH  registered binary count
- wrap  output  1  one-cycle pulse on wrap-around
- at_max  output  1  bin == 2^WIDTH-1 (decoded from registered bin)
- at_min  output  1  bin == 0 (decoded from registered bin)
- err  output  1  sticky Gray-adjacency error (see Optional Feature)

Behaviour:
- Decided: one clock, clk; reset rst is asynchronous and active-high. Everything else is synchronous to the rising edge of clk.
- Reset values while rst is high (asserted asynchronously):
  - bin = RESET_VAL
  - grey = RESET_VAL ^ (RESET_VAL >> 1)
  - wrap = 0, err = 0
  - at_max/at_min follow bin.
- grey is a direct register loaded with gray(next_bin). It is never a combinational decode of bin, so it is glitch-free.
- Latency: inputs sampled at edge N; bin, grey and wrap are valid after edge N. bin and grey always correspond.
- Priority per edge: load > incr > hold.
  - load=1: bin = load_val, grey = gray(load_val), wrap = 0. incr, dir and sat are ignored that cycle.
  - load=0, incr=1, dir=1:
    - bin < max: bin+1.
    - bin == max and sat=0: bin = 0, wrap = 1.
    - bin == max and sat=1: hold, wrap = 0.
  - load=0, incr=1, dir=0:
    - bin > 0: bin-1.
    - bin == 0 and sat=0: bin = max, wrap = 1.
    - bin == 0 and sat=1: hold, wrap = 0.
  - load=0, incr=0: hold; wrap = 0.
- wrap is high for exactly one cycle per wrap event. Consecutive wrapping steps (e.g. WIDTH=2 at a boundary every step) give one pulse per step.
- Arithmetic is modulo 2^WIDTH in unsigned binary. Gray encoding is g = b ^ (b >> 1).
- dir and sat may change on any cycle; they take effect on the next step.
- Reset mid-operation aborts any step. The first step after rst deasserts counts from RESET_VAL.
- Any non-load step changes exactly one grey bit; holds change none.

Optional Feature:
Macro GREY_COUNTER_N_CHECK_EN.
- Defined:
  - Keep a one-cycle-delayed copy of grey and a flag recording that the previous edge was a load.
  - If the previous edge was not a load, and grey differs from its delayed copy in anything other than exactly one bit, set err on the next edge.
  - err is sticky until rst. Changes of zero bits are legal.
- Undefined: err is tied to 0 and no checker logic is built.

Test Plan:
1. WIDTH=6, reset, incr=1, dir=1, sat=0, 4 cycles -> grey 0,1,3,2,6 and bin 0..4; at_min=1 only before the first step.
2. load=1, load_val=42 -> bin=42, grey=63, wrap=0. Then load_val=63 followed by one up-step with sat=0 -> bin=0, grey=0, wrap=1 for one cycle, at_min=1.
3. From bin=0, dir=0, sat=0, one step -> bin=63, grey=32, wrap=1, at_max=1. Repeat with sat=1 -> bin holds at 0, wrap=0 across 3 step cycles.
4. Assert rst asynchronously mid-count at bin=17 (between edges) -> bin=0 and grey=0 immediately, without waiting for an edge. Parameter variant RESET_VAL=5, WIDTH=4 -> reset gives bin=5, grey=7.
5. Simultaneous load=1, incr=1, load_val=10 -> bin=10, grey=15; the step is discarded and wrap=0.
6. With GREY_COUNTER_N_CHECK_EN defined:
   - Full up and down sweeps at WIDTH=6 plus random loads -> err stays 0.
   - Bench force grey=5 from grey=0 on a non-load cycle -> err=1 the next edge and remains 1 until rst.
